// File: rtl/ahb_lcd_seq.sv
// ahb_lcd_seq -- AHB-Lite slave that queues LCD command/data words in a FIFO
// and replays each one as an 8080-style parallel write cycle on the LCD pins.
//
// Optional feature: define LCD_SEQ_IRQ_EN to add the LCD_IRQ output and the
// CTRL[2] irq_en bit. Without it, CTRL[2] reads 0 and writes to it are ignored.
//
// Ports
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSEL, HREADY, HADDR,
//   HTRANS, HSIZE, HPROT,
//   HWRITE, HWDATA            AHB-Lite slave inputs (HSIZE/HPROT ignored)
//   HREADYOUT, HRESP          tied to ready / OKAY
//   HRDATA                    read data (STATUS, CTRL; CMD/DATA read 0)
//   LCD_CS, LCD_WR            active-low chip select and write strobe
//   LCD_RS, LCD_DATA          register select (0 cmd, 1 data) and data bus
//   LCD_RD                    held high
//   LCD_RST, LCD_BL_CTR       CTRL[0], CTRL[1]
//   LCD_IRQ                   (LCD_SEQ_IRQ_EN only) idle-and-empty or overflow
//
// Register map (HADDR[3:2]): 0 CMD(W), 1 DATA(W), 2 STATUS(R), 3 CTRL(RW)
//   STATUS = {22'b0, level[5:0], ovf, empty, full, busy}
module ahb_lcd_seq #(
    parameter int FIFO_DEPTH = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        LCD_CS,
    output logic        LCD_RS,
    output logic        LCD_WR,
    output logic        LCD_RD,
    output logic        LCD_RST,
    output logic [15:0] LCD_DATA,
    output logic        LCD_BL_CTR
`ifdef LCD_SEQ_IRQ_EN
    ,
    output logic        LCD_IRQ
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_e;

    // ------------------------------------------------------------------
    // AHB address/data phase pipeline
    // ------------------------------------------------------------------
    logic       addr_phase;
    logic       dp_valid_q;
    logic       dp_write_q;
    logic [1:0] dp_addr_q;

    assign addr_phase = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
        end else begin
            dp_valid_q <= addr_phase;
            if (addr_phase) begin
                dp_write_q <= HWRITE;
                dp_addr_q  <= HADDR[3:2];
            end
        end
    end

    logic wr_cmd, wr_dat, wr_ctrl, rd_status, rd_ctrl;

    assign wr_cmd    = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd0);
    assign wr_dat    = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd1);
    assign wr_ctrl   = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd3);
    assign rd_status = dp_valid_q & ~dp_write_q & (dp_addr_q == 2'd2);
    assign rd_ctrl   = dp_valid_q & ~dp_write_q & (dp_addr_q == 2'd3);

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra bit so full and empty are distinct
    // ------------------------------------------------------------------
    logic [16:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, level;
    logic        empty, full, push, push_ok, drop, pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(FIFO_DEPTH));
    assign push    = wr_cmd | wr_dat;
    // full is the pre-pop value: a push into a full FIFO drops even if a pop
    // frees a slot in the same cycle
    assign push_ok = push & ~full;
    assign drop    = push & full;

    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= {wr_dat, HWDATA[15:0]};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set
    logic ovf_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (rd_status) begin
            ovf_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // CTRL register
    // ------------------------------------------------------------------
    logic ctrl_rst_q, ctrl_bl_q, irq_en;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_rst_q <= 1'b0;
            ctrl_bl_q  <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_rst_q <= HWDATA[0];
            ctrl_bl_q  <= HWDATA[1];
        end
    end

`ifdef LCD_SEQ_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en_q <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en_q <= HWDATA[2];
        end
    end

    assign irq_en = irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Write-cycle FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy;

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = CW'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!empty) begin
                    // chain straight into the next word, CS stays low
                    pop     = 1'b1;
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        LCD_CS = 1'b1;
        LCD_WR = 1'b1;
        unique case (state_q)
            S_IDLE:   begin LCD_CS = 1'b1; LCD_WR = 1'b1; end
            S_SETUP:  begin LCD_CS = 1'b0; LCD_WR = 1'b1; end
            S_STROBE: begin LCD_CS = 1'b0; LCD_WR = 1'b0; end
            S_HOLD:   begin LCD_CS = 1'b0; LCD_WR = 1'b1; end
            default:  begin LCD_CS = 1'b1; LCD_WR = 1'b1; end
        endcase
    end

    // RS/DATA load only on SETUP entry and are held otherwise
    logic        rs_q;
    logic [15:0] data_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rs_q   <= 1'b0;
            data_q <= '0;
        end else if (pop) begin
            {rs_q, data_q} <= mem[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef LCD_SEQ_IRQ_EN
    logic irq_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_en & ((~busy & empty) | ovf_q);
        end
    end

    assign LCD_IRQ = irq_q;
`endif

    // ------------------------------------------------------------------
    // Read data and fixed outputs
    // ------------------------------------------------------------------
    always_comb begin
        HRDATA = '0;
        if (rd_status) begin
            HRDATA = {22'b0, 6'(level), ovf_q, empty, full, busy};
        end else if (rd_ctrl) begin
            HRDATA = {29'b0, irq_en, ctrl_bl_q, ctrl_rst_q};
        end
    end

    assign HREADYOUT  = 1'b1;
    assign HRESP      = 1'b0;
    assign LCD_RD     = 1'b1;
    assign LCD_RS     = rs_q;
    assign LCD_DATA   = data_q;
    assign LCD_RST    = ctrl_rst_q;
    assign LCD_BL_CTR = ctrl_bl_q;

    logic unused_inputs;
    assign unused_inputs = ^{HSIZE, HPROT, HTRANS[0], HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

endmodule

// File: tb/tb_ahb_lcd_seq.sv
// Self-checking bench for ahb_lcd_seq (default build, LCD_SEQ_IRQ_EN undefined).
module tb_ahb_lcd_seq;

    logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HREADYOUT, HRESP;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
    logic [15:0] LCD_DATA;

    int checks   = 0;
    int failures = 0;
    logic [15:0] wq[$];

    ahb_lcd_seq #(
        .FIFO_DEPTH(16),
        .SETUP_CYC (2),
        .STROBE_CYC(3),
        .HOLD_CYC  (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .LCD_CS    (LCD_CS),
        .LCD_RS    (LCD_RS),
        .LCD_WR    (LCD_WR),
        .LCD_RD    (LCD_RD),
        .LCD_RST   (LCD_RST),
        .LCD_DATA  (LCD_DATA),
        .LCD_BL_CTR(LCD_BL_CTR)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Record the data word on every WR falling edge
    always @(negedge LCD_WR) begin
        if (HRESETn === 1'b1) wq.push_back(LCD_DATA);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        tick();
        idle_bus();
        HWDATA = d;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        tick();
        idle_bus();
        d = HRDATA;
        tick();
    endtask

    // Pipelined writes, one per cycle; word k (from 1) is pushed k edges after the first address phase
    task automatic burst_write(input logic [31:0] a, input int n, input logic [15:0] base);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
            end else begin
                idle_bus();
            end
            if (i > 0) HWDATA = 32'(base + 16'(i - 1));
            tick();
        end
    endtask

    task automatic observe(input int n, output int cs_lo, output int wr_lo, output int pulses,
                           output int first_cs, output int last_cs, output int first_wr);
        logic prev_wr;
        cs_lo = 0; wr_lo = 0; pulses = 0;
        first_cs = -1; last_cs = -1; first_wr = -1;
        prev_wr = LCD_WR;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (!LCD_CS) begin
                cs_lo++;
                if (first_cs < 0) first_cs = i;
                last_cs = i;
            end
            if (!LCD_WR) begin
                wr_lo++;
                if (first_wr < 0) first_wr = i;
                if (prev_wr) pulses++;
            end
            prev_wr = LCD_WR;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_rst;
        logic        exp_bl;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] rd;
        int cs_lo, wr_lo, pulses, first_cs, last_cs, first_wr;
        bit found;
        logic [15:0] exp_q[$];

        tbl[0]  = '{1'b0, 32'h8, 32'h0, 32'h4, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'hC, 32'h2, 32'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 32'hC, 32'h0, 32'h2, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 32'hC, 32'h1, 32'h0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'hC, 32'h0, 32'h1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'hC, 32'h7, 32'h0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 32'hC, 32'h0, 32'h3, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h8, 32'h0, 32'h4, 1'b0, 1'b0};

        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HSIZE   = 3'b010;
        HPROT   = 4'h0;
        HWDATA  = '0;
        idle_bus();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        tick();

        // Reset state
        chk("rst_cs", 32'(LCD_CS), 32'h1);
        chk("rst_wr", 32'(LCD_WR), 32'h1);
        chk("rst_rd", 32'(LCD_RD), 32'h1);
        chk("rst_rs", 32'(LCD_RS), 32'h0);
        chk("rst_lcdrst", 32'(LCD_RST), 32'h0);
        chk("rst_bl", 32'(LCD_BL_CTR), 32'h0);
        chk("rst_data", 32'(LCD_DATA), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("hreadyout", 32'(HREADYOUT), 32'h1);
        chk("hresp", 32'(HRESP), 32'h0);

        // Register access table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                ahb_write(tbl[i].addr, tbl[i].wdata);
            end else begin
                ahb_read(tbl[i].addr, rd);
                chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            end
            chk($sformatf("tbl%0d_lcd_rst", i), 32'(LCD_RST), 32'(tbl[i].exp_rst));
            chk($sformatf("tbl%0d_bl", i), 32'(LCD_BL_CTR), 32'(tbl[i].exp_bl));
        end

        // Single command word: timing of one write cycle
        wq.delete();
        ahb_write(32'h0, 32'h002C);
        chk("cmd_cs_after_push", 32'(LCD_CS), 32'h1);
        observe(10, cs_lo, wr_lo, pulses, first_cs, last_cs, first_wr);
        chk("cmd_first_cs", 32'(first_cs), 32'd1);
        chk("cmd_cs_low", 32'(cs_lo), 32'd6);
        chk("cmd_first_wr", 32'(first_wr), 32'd3);
        chk("cmd_wr_low", 32'(wr_lo), 32'd3);
        chk("cmd_pulses", 32'(pulses), 32'd1);
        chk("cmd_rs_held", 32'(LCD_RS), 32'h0);
        chk("cmd_data_held", 32'(LCD_DATA), 32'h002C);
        chk("cmd_wq_size", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("cmd_wq_word", 32'(wq[0]), 32'h002C);
        ahb_read(32'h8, rd);
        chk("cmd_status_idle", rd, 32'h4);

        // Three data words: continuous CS, three strobes
        fork
            begin
                ahb_write(32'h4, 32'hF800);
                ahb_write(32'h4, 32'hF800);
                ahb_write(32'h4, 32'hF800);
            end
            observe(26, cs_lo, wr_lo, pulses, first_cs, last_cs, first_wr);
        join
        chk("b2b_first_cs", 32'(first_cs), 32'd3);
        chk("b2b_last_cs", 32'(last_cs), 32'd20);
        chk("b2b_cs_low", 32'(cs_lo), 32'd18);
        chk("b2b_first_wr", 32'(first_wr), 32'd5);
        chk("b2b_wr_low", 32'(wr_lo), 32'd9);
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_rs", 32'(LCD_RS), 32'h1);
        chk("b2b_data", 32'(LCD_DATA), 32'hF800);

        // Overflow: 21 one-per-cycle pushes; word 20 meets a full FIFO in the
        // same cycle as a pop and is dropped, word 21 refills to 16
        wq.delete();
        burst_write(32'h4, 21, 16'h0100);
        ahb_read(32'h8, rd);
        chk("ovf_status", rd, 32'h10B);
        ahb_read(32'h8, rd);
        chk("ovf_cleared_status", rd, 32'h103);
        repeat (110) tick();
        for (int k = 0; k < 19; k++) exp_q.push_back(16'h0100 + 16'(k));
        exp_q.push_back(16'h0114);
        chk("ovf_word_count", 32'(wq.size()), 32'd20);
        for (int k = 0; k < 20; k++) begin
            if (k < wq.size()) chk($sformatf("ovf_word%0d", k), 32'(wq[k]), 32'(exp_q[k]));
        end
        ahb_read(32'h8, rd);
        chk("drained_status", rd, 32'h4);

        // CTRL write in the middle of the strobe
        ahb_write(32'h0, 32'h1234);
        fork
            observe(10, cs_lo, wr_lo, pulses, first_cs, last_cs, first_wr);
            begin
                tick();
                tick();
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'hC;
                tick();
                idle_bus();
                HWDATA = 32'h3;
                chk("ctrl_rst_before", 32'(LCD_RST), 32'h0);
                chk("ctrl_strobe_active", 32'(LCD_WR), 32'h0);
                tick();
                chk("ctrl_rst_after", 32'(LCD_RST), 32'h1);
                chk("ctrl_bl_after", 32'(LCD_BL_CTR), 32'h1);
            end
        join
        chk("ctrl_wr_low", 32'(wr_lo), 32'd3);
        chk("ctrl_first_wr", 32'(first_wr), 32'd3);
        chk("ctrl_cs_low", 32'(cs_lo), 32'd6);

        // Asynchronous reset during STROBE with words still queued
        burst_write(32'h0, 3, 16'h0A00);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!LCD_WR) found = 1'b1;
            else tick();
        end
        chk("rst_wait_strobe", 32'(found), 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_cs", 32'(LCD_CS), 32'h1);
        chk("async_wr", 32'(LCD_WR), 32'h1);
        chk("async_lcdrst", 32'(LCD_RST), 32'h0);
        chk("async_bl", 32'(LCD_BL_CTR), 32'h0);
        chk("async_data", 32'(LCD_DATA), 32'h0);
        @(negedge HCLK) HRESETn = 1'b1;
        tick();
        wq.delete();
        ahb_read(32'h8, rd);
        chk("post_rst_status", rd, 32'h4);
        observe(20, cs_lo, wr_lo, pulses, first_cs, last_cs, first_wr);
        chk("post_rst_cs_low", 32'(cs_lo), 32'd0);
        chk("post_rst_pulses", 32'(pulses), 32'd0);
        chk("post_rst_wq", 32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
